// File: rtl/wb_gpio_pkg.sv
// wb_gpio_pkg: shared types and helpers for the wb_gpio peripheral.
//   gpio_reg_e : register index carried in the upper address bits
//   DATA_W     : Wishbone data width (16-bit J1 bus)
//   n_words()  : number of 16-bit words needed to cover a pin vector
//   wsel_w()   : width of the word-select address field
package wb_gpio_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    REG_IN      = 3'd0,
    REG_OUT     = 3'd1,
    REG_DIR     = 3'd2,
    REG_RISE_EN = 3'd3,
    REG_FALL_EN = 3'd4,
    REG_STATUS  = 3'd5,
    REG_SET     = 3'd6,
    REG_CLR     = 3'd7
  } gpio_reg_e;

  function automatic int n_words(input int width);
    return (width + DATA_W - 1) / DATA_W;
  endfunction

  // A single-word block still gets a one-bit word field so the address
  // layout stays {reg, word} for every WIDTH.
  function automatic int wsel_w(input int width);
    int nw;
    nw = n_words(width);
    return (nw > 1) ? $clog2(nw) : 1;
  endfunction

endpackage

// File: rtl/wb_gpio_if.sv
// wb_gpio_if: Wishbone B4 classic bus bundle between the J1 master and the
// GPIO slave. ADR_W = 3 + word-select width.
//   master: drives cyc/stb/we/adr/sel/dat_i, receives dat_o/ack
//   slave : the reverse
interface wb_gpio_if
  import wb_gpio_pkg::*;
#(
  parameter int ADR_W = 5
);
  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic              wb_we_i;
  logic [ADR_W-1:0]  wb_adr_i;
  logic [1:0]        wb_sel_i;
  logic [DATA_W-1:0] wb_dat_i;
  logic [DATA_W-1:0] wb_dat_o;
  logic              wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: multi-stage synchroniser for an asynchronous pin vector
// plus a one-cycle delay register for edge detection. Edges are unmasked.
//   clk_i, rst_i : clock, synchronous active-high reset
//   pins         : asynchronous pad inputs
//   s            : synchronised pin state
//   rise, fall   : s & ~p, ~s & p (p = s delayed one clock)
module gpio_sync_edge #(
  parameter int WIDTH  = 36,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] sync_r [STAGES];
  logic [WIDTH-1:0] prev_r;

  // Synchroniser chain and delayed copy; both clear on reset so a pin held
  // high through reset shows up as a rising edge afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_r[i] <= '0;
      end
      prev_r <= '0;
    end else begin
      sync_r[0] <= pins;
      for (int i = 1; i < STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign s    = sync_r[STAGES-1];
  assign rise = s & ~prev_r;
  assign fall = ~s & prev_r;

endmodule

// File: rtl/wb_gpio.sv
// wb_gpio: Wishbone B4 classic GPIO slave with direction control, atomic
// set/clear, synchronised inputs and masked edge interrupts.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : Wishbone slave port, adr = {reg[2:0], word[WSEL-1:0]}
//   gpio_i       : asynchronous pad inputs
//   gpio_o       : OUT register
//   gpio_oe      : DIR register (1 = pin driven)
//   irq_o        : OR of all STATUS bits
module wb_gpio
  import wb_gpio_pkg::*;
#(
  parameter int WIDTH       = 36,
  parameter int SYNC_STAGES = 2,
  localparam int NW         = n_words(WIDTH),
  localparam int WSEL       = wsel_w(WIDTH),
  localparam int PAD_W      = NW * DATA_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  wb_gpio_if.slave         bus,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq_o
);

  logic              ack_r;
  logic [DATA_W-1:0] dat_r;
  logic [WIDTH-1:0]  out_r, dir_r, rise_en_r, fall_en_r, status_r;
  logic [WIDTH-1:0]  out_nxt_s, dir_nxt_s, rise_en_nxt_s, fall_en_nxt_s, status_nxt_s;
  logic [WIDTH-1:0]  sync_s, rise_s, fall_s, edge_s, status_clr_s;
  logic              req_s, wr_s;
  gpio_reg_e         reg_s;
  logic [WSEL-1:0]   word_s;
  logic [DATA_W-1:0] lane_mask_s, rdata_s;
  logic [PAD_W-1:0]  wmask_pad_s, wdata_pad_s, rd_pad_s;
  logic [WIDTH-1:0]  wmask_s, wbits_s;

  gpio_sync_edge #(
    .WIDTH (WIDTH),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .pins (gpio_i),
    .s    (sync_s),
    .rise (rise_s),
    .fall (fall_s)
  );

  // Bus decode: place the byte-lane mask and write data at the addressed word
  // of a padded vector, then trim to WIDTH so bits above the pin count and
  // out-of-range words never reach a register.
  always_comb begin
    req_s       = bus.wb_cyc_i & bus.wb_stb_i & ~ack_r;
    wr_s        = req_s & bus.wb_we_i;
    reg_s       = gpio_reg_e'(bus.wb_adr_i[WSEL+2:WSEL]);
    word_s      = bus.wb_adr_i[WSEL-1:0];
    lane_mask_s = {{8{bus.wb_sel_i[1]}}, {8{bus.wb_sel_i[0]}}};
    wmask_pad_s = '0;
    wdata_pad_s = '0;
    for (int w = 0; w < NW; w++) begin
      wmask_pad_s[w*DATA_W +: DATA_W] = (word_s == WSEL'(w)) ? lane_mask_s : '0;
      wdata_pad_s[w*DATA_W +: DATA_W] = bus.wb_dat_i;
    end
    wmask_s = wr_s ? wmask_pad_s[WIDTH-1:0] : '0;
    wbits_s = wdata_pad_s[WIDTH-1:0] & wmask_s;
  end

  // Register next-state. wmask_s is zero unless a write is committing, so
  // every update below is a no-op outside a write. Edges are OR-ed in after
  // the W1C so a same-cycle edge keeps the STATUS bit set.
  always_comb begin
    out_nxt_s     = out_r;
    dir_nxt_s     = dir_r;
    rise_en_nxt_s = rise_en_r;
    fall_en_nxt_s = fall_en_r;
    status_clr_s  = '0;
    case (reg_s)
      REG_OUT:     out_nxt_s     = (out_r & ~wmask_s) | wbits_s;
      REG_DIR:     dir_nxt_s     = (dir_r & ~wmask_s) | wbits_s;
      REG_RISE_EN: rise_en_nxt_s = (rise_en_r & ~wmask_s) | wbits_s;
      REG_FALL_EN: fall_en_nxt_s = (fall_en_r & ~wmask_s) | wbits_s;
      REG_STATUS:  status_clr_s  = wbits_s;
      REG_SET:     out_nxt_s     = out_r | wbits_s;
      REG_CLR:     out_nxt_s     = out_r & ~wbits_s;
      default:     out_nxt_s     = out_r;
    endcase
    edge_s       = (rise_s & rise_en_r) | (fall_s & fall_en_r);
    status_nxt_s = (status_r & ~status_clr_s) | edge_s;
  end

  // Read mux: select the register, then the addressed 16-bit word. Words at
  // or above NW match no loop index and read 0.
  always_comb begin
    case (reg_s)
      REG_IN:      rd_pad_s = PAD_W'(sync_s);
      REG_OUT:     rd_pad_s = PAD_W'(out_r);
      REG_DIR:     rd_pad_s = PAD_W'(dir_r);
      REG_RISE_EN: rd_pad_s = PAD_W'(rise_en_r);
      REG_FALL_EN: rd_pad_s = PAD_W'(fall_en_r);
      REG_STATUS:  rd_pad_s = PAD_W'(status_r);
      default:     rd_pad_s = '0;
    endcase
    rdata_s = '0;
    for (int w = 0; w < NW; w++) begin
      rdata_s = rdata_s | ((word_s == WSEL'(w)) ? rd_pad_s[w*DATA_W +: DATA_W] : '0);
    end
  end

  // State registers and registered bus response. Reset has priority, which
  // also discards a write whose ack would have risen on this edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_r     <= 1'b0;
      dat_r     <= 16'd0;
      out_r     <= '0;
      dir_r     <= '0;
      rise_en_r <= '0;
      fall_en_r <= '0;
      status_r  <= '0;
    end else begin
      ack_r     <= req_s;
      dat_r     <= (req_s & ~bus.wb_we_i) ? rdata_s : 16'd0;
      out_r     <= out_nxt_s;
      dir_r     <= dir_nxt_s;
      rise_en_r <= rise_en_nxt_s;
      fall_en_r <= fall_en_nxt_s;
      status_r  <= status_nxt_s;
    end
  end

  assign bus.wb_ack_o = ack_r;
  assign bus.wb_dat_o = dat_r;
  assign gpio_o       = out_r;
  assign gpio_oe      = dir_r;
  assign irq_o        = |status_r;

endmodule

// File: doc/wb_gpio.md
# wb_gpio

Parametrised Wishbone B4 classic slave GPIO block for the J1 system on the C5GX board, replacing the fixed GPIO wiring with a configurable-width peripheral. It provides per-pin direction control, atomic set/clear of outputs, a synchronised input path, and rising/falling edge interrupts. It sits on the 16-bit J1 Wishbone data bus next to `wb_rom`. The top level builds the tristate buffers on `GPIO[35:0]` from `gpio_o`/`gpio_oe`.

## Interface
- `WIDTH`, 36: number of GPIO pins, 1..64.
- `SYNC_STAGES`, 2: input synchroniser depth, 2..4.
- `WSEL` (derived): max(1, clog2(ceil(WIDTH/16))). This is the width of the word-select field.
- `clk_i`  in  1  system clock. Single clock domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i`  in  1 each  Wishbone cycle, strobe and write enable.
- `wb_adr_i`  in  3+WSEL  register select is `{reg[2:0], word[WSEL-1:0]}`; the word field is least significant.
- `wb_sel_i`  in  2  byte selects. `[1]` selects bits 15:8 and `[0]` selects bits 7:0.
- `wb_dat_i`  in  16  write data.
- `wb_dat_o`  out  16  read data.
- `wb_ack_o`  out  1  transfer acknowledge.
- `gpio_i`  in  WIDTH  pad inputs. These are asynchronous.
- `gpio_o`  out  WIDTH  output data register.
- `gpio_oe`  out  WIDTH  output enable, equal to DIR. 1 means the pin is driven.
- `irq_o`  out  1  level interrupt, equal to |STATUS.

## Operation
- Register map. Each register is an array of ceil(WIDTH/16) 16-bit words; word w holds pins 16w+15..16w.
  - 0 IN: read-only. Holds the synchronised pin state.
  - 1 OUT: read/write.
  - 2 DIR: read/write.
  - 3 RISE_EN: read/write.
  - 4 FALL_EN: read/write.
  - 5 STATUS: a written 1 clears the bit (W1C).
  - 6 SET: writing 1 sets the corresponding OUT bits. Reads return 0.
  - 7 CLR: writing 1 clears the corresponding OUT bits. Reads return 0.
- Byte lanes that are not selected are never modified. Byte selects also apply to W1C, SET and CLR.
- Bits at or above WIDTH read as 0 and ignore writes. A word index at or above ceil(WIDTH/16) reads 0 and ignores writes, but is still acked.
- Edge detection:
  - `s` is the synchronised input; `p` is `s` delayed one cycle.
  - A rising edge is `s & ~p & RISE_EN`. A falling edge is `~s & p & FALL_EN`.
  - Either edge sets the pin's STATUS bit.
- STATUS ignores the pin direction: output pins loop back through `gpio_i` as usual.
- If an edge and a W1C for the same bit occur in the same cycle, the set wins and the bit stays 1.
- Disabling RISE_EN or FALL_EN does not clear bits already pending in STATUS.
- Handshake: `wb_ack_o` is registered and asserts the cycle after `cyc&stb&~ack`. It is high for exactly one cycle, so each access takes 2 cycles.
  - The write takes effect on the same edge that raises ack.
  - `wb_dat_o` is registered and valid while ack is high. It is 0 otherwise.
  - If `cyc` drops while ack is pending, ack still pulses for one cycle and the write has already committed. There is no error or retry.
- Reset clears all registers, the synchroniser chain and `p`.
  - After reset, `gpio_o`=0, `gpio_oe`=0, `irq_o`=0, `wb_ack_o`=0 and `wb_dat_o`=0.
  - Because the chain and `p` both reset to 0, an input held high through reset produces a rising edge after release if RISE_EN is set.
  - Asserting reset mid-transfer drops ack in the next cycle and discards the write.

## Timing
- A pin change reaches IN after SYNC_STAGES clocks.
- STATUS sets one clock after IN changes. `irq_o` rises on that same edge, since it is combinational from STATUS.
- Write to OUT or DIR: the new value appears on `gpio_o`/`gpio_oe` at the edge where ack rises, one clock after the strobe.
- Read latency is one clock (strobe to ack with data).
- Back-to-back strobes give one ack every other cycle.

## Structure
- `wb_gpio_pkg` holds:
  - the register-index enum `gpio_reg_e` (IN, OUT, DIR, RISE_EN, FALL_EN, STATUS, SET, CLR);
  - `localparam DATA_W = 16`;
  - a function `n_words(width)`.
- Sub-module `gpio_sync_edge`: a per-vector synchroniser of depth SYNC_STAGES plus the delay register. It outputs `s`, `rise` and `fall` (unmasked); the RISE_EN/FALL_EN masks are applied in `wb_gpio`.
- `wb_gpio` contains the Wishbone decode, the registers, the read mux and the IRQ logic. Expected size is about 200 lines.

## Test plan
- Reset, then read every register at every word index → all reads return 0; `gpio_oe`=0; `irq_o`=0; each read is acked one cycle after the strobe.
- WIDTH=36:
  - Write DIR word0=FFFF, word1=FFFF and word2=000F, then OUT word2=00FF with sel=01 → `gpio_oe`=F_FFFF_FFFF and `gpio_o[35:32]`=F.
  - Reading OUT word2 returns 000F (bits above WIDTH read 0).
- SET word0=0101, then CLR word0=0001, starting from OUT=0 → `gpio_o[15:0]` goes to 0101, then 0100. Reads of SET and CLR return 0.
- RISE_EN word0=0001 with `gpio_i[0]` toggled 0→1 → IN bit0 reads 1 after 2 clocks; STATUS bit0 and `irq_o` go high on the 3rd clock. A W1C of 0001 drops `irq_o`.
- FALL_EN bit1 set; apply a falling edge on pin 1 in the same cycle as a W1C of bit1 → STATUS bit1 stays 1.
- Assert `rst_i` during a pending write to OUT → ack is not seen, OUT stays 0 and all outputs return to their reset values.
